// File: rtl/demux_32_1_to_2_reg.sv
// Purpose: registered 1-to-2 demux; steers each accepted word into channel A (in_sel=0) or B (in_sel=1).
// Latency: 1 cycle (word accepted at edge N is presented after edge N); 1 word/cycle per channel.
// Backpressure: in_ready follows only the selected channel (strict head-of-line, never reorders).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_data/in_sel           word and route select, sampled when in_valid & in_ready
//   in_valid/in_ready        producer handshake
//   a_data/a_valid/a_ready   channel A output register and consumer handshake
//   b_data/b_valid/b_ready   channel B output register and consumer handshake
//   a_count/b_count          completed output handshakes per channel, wrapping modulo 2^CNT_W
module demux_32_1_to_2_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  chan_state_t      a_state_q, a_state_d;
  chan_state_t      b_state_q, b_state_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

  logic a_drain, b_drain;
  logic acc, a_load, b_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_state_q <= EMPTY;
      b_state_q <= EMPTY;
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
    end
  end

  always_comb begin
    a_drain = (a_state_q == FULL) & a_ready;
    b_drain = (b_state_q == FULL) & b_ready;

    // A FULL channel can still take a word on the same edge it drains.
    in_ready = in_sel ? ((b_state_q == EMPTY) | b_ready)
                      : ((a_state_q == EMPTY) | a_ready);
    acc      = in_valid & in_ready;
    a_load   = acc & ~in_sel;
    b_load   = acc &  in_sel;

    a_state_d = a_state_q;
    b_state_d = b_state_q;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;

    // Load wins over drain so drain-and-reload keeps the channel FULL.
    if (a_load) begin
      a_state_d = FULL;
      a_data_d  = in_data;
    end else if (a_drain) begin
      a_state_d = EMPTY;
    end

    if (b_load) begin
      b_state_d = FULL;
      b_data_d  = in_data;
    end else if (b_drain) begin
      b_state_d = EMPTY;
    end

    if (a_drain) a_cnt_d = a_cnt_q + CNT_W'(1);
    if (b_drain) b_cnt_d = b_cnt_q + CNT_W'(1);
  end

  assign a_valid = (a_state_q == FULL);
  assign b_valid = (b_state_q == FULL);
  assign a_data  = a_data_q;
  assign b_data  = b_data_q;
  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;

endmodule

// File: tb/tb_demux_32_1_to_2_reg.sv
module tb_demux_32_1_to_2_reg;
  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_sel, in_valid, a_ready, b_ready;
  logic          in_ready, a_valid, b_valid;
  logic [W-1:0]  a_data, b_data;
  logic [CW-1:0] a_count, b_count;

  // Second instance with narrow counters so wrap-around is reached quickly.
  logic          in_ready4, a_valid4, b_valid4;
  logic [W-1:0]  a_data4, b_data4;
  logic [3:0]    a_count4, b_count4;

  demux_32_1_to_2_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  demux_32_1_to_2_reg #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready4), .a_data(a_data4), .a_valid(a_valid4), .a_ready(a_ready),
    .b_data(b_data4), .b_valid(b_valid4), .b_ready(b_ready),
    .a_count(a_count4), .b_count(b_count4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt_a  = 0;
  int cnt_b  = 0;
  int n_acc  = 0;
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle at negedge+2 compare outputs with the scoreboard head,
  // then retire the head if the consumer takes it at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_a.delete();
        exp_b.delete();
        cnt_a = 0;
        cnt_b = 0;
      end else begin
        chk("a_valid", a_valid, exp_a.size() != 0);
        chk("b_valid", b_valid, exp_b.size() != 0);
        chk("a_valid_w4", a_valid4, exp_a.size() != 0);
        chk("b_valid_w4", b_valid4, exp_b.size() != 0);
        if (exp_a.size() != 0) chk("a_data", a_data, exp_a[0]);
        if (exp_b.size() != 0) chk("b_data", b_data, exp_b[0]);
        chk("a_count", a_count, cnt_a % 65536);
        chk("b_count", b_count, cnt_b % 65536);
        chk("a_count_w4", a_count4, cnt_a % 16);
        chk("b_count_w4", b_count4, cnt_b % 16);
        if (exp_a.size() != 0 && a_ready) begin
          void'(exp_a.pop_front());
          cnt_a++;
        end
        if (exp_b.size() != 0 && b_ready) begin
          void'(exp_b.pop_front());
          cnt_b++;
        end
      end
    end
  end

  // Driver: apply one cycle of stimulus; a word is accepted iff its channel
  // will have room after this cycle's drain, i.e. its queue is empty now.
  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit ar, input bit br);
    bit exp_rdy;
    @(negedge clk);
    #1;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #2;
    exp_rdy = s ? (exp_b.size() == 0) : (exp_a.size() == 0);
    chk("in_ready", in_ready, exp_rdy);
    chk("in_ready_w4", in_ready4, exp_rdy);
    if (v && exp_rdy && !rst) begin
      if (s) exp_b.push_back(d);
      else   exp_a.push_back(d);
      n_acc++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
    #2;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_in_ready", in_ready, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    rst = 1'b0;

    // Streaming into A.
    for (int i = 1; i <= 4; i++) step(1, 0, W'(i), 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Stall with a pending word for A.
    step(1, 0, 32'hDEADBEEF, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 32'hCAFEF00D, 0, 0);
    step(1, 0, 32'hCAFEF00D, 1, 0);
    step(0, 0, 0, 1, 0);

    // Head-of-line: A stalled, B empty.
    step(1, 0, 32'h11111111, 0, 0);
    step(1, 0, 32'h22222222, 0, 0);
    step(1, 1, 32'h12345678, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);

    // Asynchronous reset mid-cycle with both channels FULL.
    step(1, 0, 32'hAAAA0001, 0, 0);
    step(1, 1, 32'hBBBB0002, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("arst_a_valid", a_valid, 0);
    chk("arst_b_valid", b_valid, 0);
    chk("arst_a_data", a_data, 0);
    chk("arst_b_data", b_data, 0);
    chk("arst_a_count", a_count, 0);
    chk("arst_b_count", b_count, 0);
    chk("arst_in_ready_b", in_ready, 1);
    in_sel = 1'b0;
    #1;
    chk("arst_in_ready_a", in_ready, 1);
    n_acc = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b0;

    // 17 A handshakes: narrow counter wraps to 1.
    for (int i = 0; i < 17; i++) step(1, 0, $urandom, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("wrap_a_count_w4", a_count4, 1);
    chk("wrap_a_count", a_count, 17);

    // Interleave: alternating select first, then fully random, random readies.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, (i < 200) ? i[0] : 1'($urandom), $urandom,
           1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
    chk("drained_a", exp_a.size(), 0);
    chk("drained_b", exp_b.size(), 0);
    chk("total_count", int'(a_count) + int'(b_count), n_acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
